// File: rtl/aes_stream_decrypt.sv
// aes_stream_decrypt: FIFO-buffered AES-128 ECB/CBC decryption stream engine
// around an iterative inverse-cipher core (one round per clock).

module aes_dec_core (
    input  logic         clk,
    input  logic         reset,
    input  logic         aes_start,
    input  logic [127:0] aes_key,
    input  logic [127:0] aes_msg_enc,
    output logic [127:0] aes_msg_dec,
    output logic         aes_done
);
    typedef enum logic [1:0] {C_IDLE, C_RUN, C_DONE} cst_t;

    cst_t         cst;
    cst_t         cst_n;
    logic [127:0] st;
    logic [127:0] rk;
    logic [127:0] rk10;
    logic [127:0] rk_nxt;
    logic [127:0] st_nxt;
    logic [3:0]   rnd;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Field inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w0 = w0 ^ sub_rot(w3) ^ {rcon(r), 24'h0};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Walk the schedule backwards: round key r -> round key r-1
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w3 = w3 ^ w2;
        w2 = w2 ^ w1;
        w1 = w1 ^ w0;
        w0 = w0 ^ sub_rot(w3) ^ {rcon(r), 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] last_key(input logic [127:0] k);
        logic [127:0] t;
        t = k;
        for (int r = 1; r <= 10; r++) t = key_fwd(t, 4'(r));
        return t;
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic mix);
        logic [127:0] t;
        logic [127:0] m;
        logic [7:0]   a0, a1, a2, a3;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            t[127-8*i -: 8] =
                inv_sbox(s[127-8*((i%4) + 4*(((i/4) - (i%4) + 4) % 4)) -: 8]);
        end
        t = t ^ k;
        m = t;
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[127-32*c -: 8];
                a1 = t[119-32*c -: 8];
                a2 = t[111-32*c -: 8];
                a3 = t[103-32*c -: 8];
                m[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                m[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                m[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                m[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end
        end
        return m;
    endfunction

    always_comb begin
        rk10   = last_key(aes_key);
        rk_nxt = key_inv(rk, rnd);
        st_nxt = inv_round(st, rk_nxt, rnd != 4'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) cst <= C_IDLE;
        else       cst <= cst_n;
    end

    always_comb begin
        cst_n = cst;
        case (cst)
            C_IDLE:  if (aes_start)   cst_n = C_RUN;
            C_RUN:   if (rnd == 4'd1) cst_n = C_DONE;
            C_DONE:  if (!aes_start)  cst_n = C_IDLE;
            default: cst_n = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= '0;
            rk          <= '0;
            rnd         <= '0;
            aes_done    <= 1'b0;
            aes_msg_dec <= '0;
        end else begin
            if (cst == C_IDLE && aes_start) begin
                st  <= aes_msg_enc ^ rk10;
                rk  <= rk10;
                rnd <= 4'd10;
            end
            if (cst == C_RUN) begin
                st  <= st_nxt;
                rk  <= rk_nxt;
                rnd <= rnd - 4'd1;
                if (rnd == 4'd1) begin
                    aes_done    <= 1'b1;
                    aes_msg_dec <= st_nxt;
                end
            end
            if (cst == C_DONE && !aes_start) aes_done <= 1'b0;
        end
    end
endmodule

module aes_stream_decrypt #(
    parameter int IN_DEPTH       = 4,
    parameter int OUT_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_load,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic         err_timeout
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int TW  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_WRITE, S_ABORT, S_REL
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [127:0]   imem [IN_DEPTH];
    logic [127:0]   omem [OUT_DEPTH];
    logic [IAW-1:0] iwp, irp;
    logic [IAW:0]   icnt;
    logic [OAW-1:0] owp, orp;
    logic [OAW:0]   ocnt;
    logic [127:0]   last_q;
    logic [127:0]   key_r, chain_r, cur_ct, pt;
    logic           mode_r;
    logic [TW-1:0]  timer;
    logic           in_push, in_pop, opush, opop, cfg_ok;
    logic           core_rst, aes_start, aes_done;
    logic [127:0]   aes_msg_dec;

    aes_dec_core AES (
        .clk         (clk),
        .reset       (core_rst),
        .aes_start   (aes_start),
        .aes_key     (key_r),
        .aes_msg_enc (cur_ct),
        .aes_msg_dec (aes_msg_dec),
        .aes_done    (aes_done)
    );

    assign core_rst  = ~reset;
    assign aes_start = reset & (state == S_RUN);
    assign in_ready  = reset & (icnt != (IAW+1)'(IN_DEPTH));
    assign out_valid = (ocnt != '0);
    assign out_data  = out_valid ? omem[orp] : last_q;
    assign busy      = (state != S_IDLE) | (icnt != '0);
    assign in_push   = in_valid & in_ready;
    assign in_pop    = (state == S_LOAD);
    assign opush     = (state == S_WRITE);
    assign opop      = out_valid & out_ready;
    assign cfg_ok    = cfg_load & ~busy;
    assign pt        = aes_msg_dec ^ (mode_r ? chain_r : 128'h0);

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Only load when a result slot is free; one block in flight at a time
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (icnt != '0 && ocnt < (OAW+1)'(OUT_DEPTH)) state_n = S_LOAD;
            S_LOAD:  state_n = S_RUN;
            S_RUN: begin
                if (aes_done)                           state_n = S_WRITE;
                else if (timer == TW'(TIMEOUT_CYCLES-1)) state_n = S_ABORT;
            end
            S_WRITE: state_n = S_REL;
            S_ABORT: state_n = S_REL;
            S_REL:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_push) imem[iwp] <= in_data;
        if (opush)   omem[owp] <= pt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            iwp    <= '0;
            irp    <= '0;
            icnt   <= '0;
            owp    <= '0;
            orp    <= '0;
            ocnt   <= '0;
            last_q <= '0;
        end else begin
            if (in_push) iwp <= iwp + 1'b1;
            if (in_pop)  irp <= irp + 1'b1;
            case ({in_push, in_pop})
                2'b10:   icnt <= icnt + 1'b1;
                2'b01:   icnt <= icnt - 1'b1;
                default: ;
            endcase
            if (opush) owp <= owp + 1'b1;
            if (opop) begin
                orp    <= orp + 1'b1;
                last_q <= omem[orp];
            end
            case ({opush, opop})
                2'b10:   ocnt <= ocnt + 1'b1;
                2'b01:   ocnt <= ocnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_r       <= '0;
            chain_r     <= '0;
            mode_r      <= 1'b0;
            cur_ct      <= '0;
            timer       <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (cfg_ok) begin
                key_r       <= key;
                chain_r     <= iv;
                mode_r      <= mode;
                err_timeout <= 1'b0;
            end
            if (state == S_LOAD) begin
                cur_ct <= imem[irp];
                timer  <= '0;
            end
            if (state == S_RUN)             timer       <= timer + 1'b1;
            if (state == S_WRITE && mode_r) chain_r     <= cur_ct;
            if (state == S_ABORT)           err_timeout <= 1'b1;
        end
    end
endmodule
